// File: rtl/seven_segment_scanner.sv
// Time-multiplexed common-anode seven-segment scanner: one digit per prescaler
// strobe, active-low segments and digit selects, inputs snapshotted once per frame.
module seven_segment_scanner #(
  parameter int n_digits     = 4,
  parameter int strobe_width = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*n_digits-1:0] number,
  input  logic [n_digits-1:0]   dots,
  input  logic                  blank_zeros,
  output logic [7:0]            abcdefgh,
  output logic [n_digits-1:0]   digit,
  output logic                  frame_start
);

  localparam int IW = (n_digits > 1) ? $clog2(n_digits) : 1;

  logic [strobe_width-1:0] cnt_q;
  logic [IW-1:0]           idx_q;
  logic [IW-1:0]           nidx;
  logic                    strobe;
  logic                    frame_load;

  logic [4*n_digits-1:0]   num_q;
  logic [n_digits-1:0]     dots_q;
  logic                    blank_q;

  logic [4*n_digits-1:0]   src_num;
  logic [n_digits-1:0]     src_dots;
  logic                    src_blank;

  logic [3:0]              nib;
  logic                    dot;
  logic                    blank;
  logic                    run;
  int unsigned             j;

  logic [7:0]              seg_q, seg_d;
  logic [n_digits-1:0]     digit_q, digit_d;
  logic                    frame_q;

  function automatic logic [6:0] seg7(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'b1111110;
      4'h1: s = 7'b0110000;
      4'h2: s = 7'b1101101;
      4'h3: s = 7'b1111001;
      4'h4: s = 7'b0110011;
      4'h5: s = 7'b1011011;
      4'h6: s = 7'b1011111;
      4'h7: s = 7'b1110000;
      4'h8: s = 7'b1111111;
      4'h9: s = 7'b1111011;
      4'hA: s = 7'b1110111;
      4'hB: s = 7'b0011111;
      4'hC: s = 7'b1001110;
      4'hD: s = 7'b0111101;
      4'hE: s = 7'b1001111;
      default: s = 7'b1000111;
    endcase
    return s;
  endfunction

  assign strobe = &cnt_q;

  always_comb begin
    nidx       = (idx_q == IW'(n_digits - 1)) ? '0 : idx_q + 1'b1;
    frame_load = (nidx == '0);
    // The frame's first digit bypasses the snapshot it is loading in the same cycle.
    src_num    = frame_load ? number      : num_q;
    src_dots   = frame_load ? dots        : dots_q;
    src_blank  = frame_load ? blank_zeros : blank_q;

    nib   = '0;
    dot   = 1'b0;
    blank = 1'b0;
    run   = 1'b1;
    j     = 0;
    // Walk from the leftmost digit so run tracks "all nibbles from here up are zero".
    for (int unsigned k = 0; k < n_digits; k++) begin
      j   = n_digits - 1 - k;
      run = run & (src_num[4*j +: 4] == 4'h0);
      if (nidx == IW'(j)) begin
        nib   = src_num[4*j +: 4];
        dot   = src_dots[j];
        blank = run & src_blank & (j != 0);
      end
    end

    seg_d   = {(blank ? 7'h7F : ~seg7(nib)), ~dot};
    digit_d = ~(n_digits'(1) << nidx);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      idx_q   <= IW'(n_digits - 1);
      seg_q   <= '1;
      digit_q <= '1;
      frame_q <= 1'b0;
      num_q   <= '0;
      dots_q  <= '0;
      blank_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_q + 1'b1;
      frame_q <= strobe & frame_load;
      if (strobe) begin
        idx_q   <= nidx;
        seg_q   <= seg_d;
        digit_q <= digit_d;
        if (frame_load) begin
          num_q   <= number;
          dots_q  <= dots;
          blank_q <= blank_zeros;
        end
      end
    end
  end

  assign abcdefgh    = seg_q;
  assign digit       = digit_q;
  assign frame_start = frame_q;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Bench for seven_segment_scanner: per-cycle model comparison plus directed literal checks.
module tb_seven_segment_scanner;

  localparam int ND = 4;
  localparam int SW = 2;
  localparam int PERIOD = 1 << SW;

  logic          clk = 1'b0;
  logic          reset;
  logic [4*ND-1:0] number;
  logic [ND-1:0] dots;
  logic          blank_zeros;
  logic [7:0]    abcdefgh;
  logic [ND-1:0] digit;
  logic          frame_start;

  int n_checks = 0;
  int n_fail   = 0;

  seven_segment_scanner #(.n_digits(ND), .strobe_width(SW)) dut (
    .clk(clk), .reset(reset), .number(number), .dots(dots),
    .blank_zeros(blank_zeros), .abcdefgh(abcdefgh), .digit(digit),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: time since reset counts strobes; strobe k shows digit k mod ND.
  logic [6:0] SEG [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                           7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                           7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                           7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};
  int          m_cyc = 0;
  int          m_strobes = 0;
  bit          m_valid = 0;
  logic [4*ND-1:0] m_num;
  logic [ND-1:0]   m_dots;
  logic            m_bz;
  logic [7:0]      e_seg;
  logic [ND-1:0]   e_dig;
  logic            e_fs;

  always @(posedge clk) begin
    if (reset) begin
      m_valid = 1; m_cyc = 0; m_strobes = 0;
      m_num = '0; m_dots = '0; m_bz = 0;
      e_seg = 8'hFF; e_dig = '1; e_fs = 0;
    end else if (m_valid) begin
      e_fs = 0;
      if (m_cyc % PERIOD == PERIOD - 1) begin
        int d;
        logic [3:0] nb;
        logic bl;
        d = m_strobes % ND;
        if (d == 0) begin m_num = number; m_dots = dots; m_bz = blank_zeros; end
        nb = 4'((m_num >> (4*d)) & 16'hF);
        bl = m_bz && d != 0 && ((m_num >> (4*d)) == 0);
        e_seg = {(bl ? 7'h7F : ~SEG[nb]), ~m_dots[d]};
        e_dig = '1;
        e_dig[d] = 1'b0;
        e_fs = (d == 0);
        m_strobes++;
      end
      m_cyc++;
    end
    #1;
    if (m_valid) begin
      chk("model_seg", 32'(abcdefgh), 32'(e_seg));
      chk("model_digit", 32'(digit), 32'(e_dig));
      chk("model_frame", 32'(frame_start), 32'(e_fs));
    end
  end

  task automatic wait_frame(input string nm);
    int n = 0;
    do begin @(negedge clk); n++; end while (frame_start !== 1'b1 && n < 40);
    if (frame_start !== 1'b1) chk({nm, "_frame_timeout"}, 32'(frame_start), 32'd1);
  endtask

  task automatic wait_digit(input string nm, input logic [ND-1:0] target);
    int n = 0;
    do begin @(negedge clk); n++; end while (digit !== target && n < 40);
    chk({nm, "_digit"}, 32'(digit), 32'(target));
  endtask

  initial begin
    int n;
    reset = 1; number = '0; dots = '0; blank_zeros = 0;
    repeat (2) @(negedge clk);
    reset = 0;
    chk("reset_seg", 32'(abcdefgh), 32'hFF);
    chk("reset_digit", 32'(digit), 32'hF);
    chk("reset_frame", 32'(frame_start), 32'd0);

    // first strobe lands on the 4th clock after release
    n = 0;
    do begin @(negedge clk); n++; end while (frame_start !== 1'b1 && n < 40);
    chk("first_strobe_latency", 32'(n), 32'd4);
    chk("t1_d0_digit", 32'(digit), 32'hE);
    chk("t1_d0_seg", 32'(abcdefgh), 32'h03);
    @(negedge clk);
    chk("t1_pulse_one_cycle", 32'(frame_start), 32'd0);

    number = 16'h12AF; dots = 4'b0100;
    wait_frame("t2");
    chk("t2_d0_F", 32'(abcdefgh), 32'b0111_0001);
    wait_digit("t2_d1", 4'b1101);
    chk("t2_d1_A", 32'(abcdefgh), 32'b0001_0001);
    wait_digit("t2_d2", 4'b1011);
    chk("t2_d2_2dot", 32'(abcdefgh), 32'b0010_0100);
    wait_digit("t2_d3", 4'b0111);
    chk("t2_d3_1", 32'(abcdefgh), 32'b1001_1111);

    blank_zeros = 1; number = 16'h0050; dots = '0;
    wait_frame("t3");
    chk("t3_d0_0", 32'(abcdefgh), 32'h03);
    wait_digit("t3_d1", 4'b1101);
    chk("t3_d1_5", 32'(abcdefgh), 32'b0100_1001);
    wait_digit("t3_d2", 4'b1011);
    chk("t3_d2_blank", 32'(abcdefgh), 32'hFF);
    wait_digit("t3_d3", 4'b0111);
    chk("t3_d3_blank", 32'(abcdefgh), 32'hFF);

    number = 16'h0000;
    wait_frame("t4");
    chk("t4_d0_0", 32'(abcdefgh), 32'h03);
    wait_digit("t4_d1", 4'b1101);
    chk("t4_d1_blank", 32'(abcdefgh), 32'hFF);

    blank_zeros = 0; number = 16'h1111;
    wait_frame("t5");
    wait_digit("t5_d2", 4'b1011);
    number = 16'h2222;
    wait_digit("t5_d3", 4'b0111);
    chk("t5_d3_still_1", 32'(abcdefgh), 32'b1001_1111);
    wait_frame("t5b");
    chk("t5_d0_2", 32'(abcdefgh), 32'b0010_0101);
    wait_digit("t5_d1", 4'b1101);
    chk("t5_d1_2", 32'(abcdefgh), 32'b0010_0101);

    wait_digit("t6_d2", 4'b1011);
    reset = 1;
    @(negedge clk);
    chk("t6_dark_seg", 32'(abcdefgh), 32'hFF);
    chk("t6_dark_digit", 32'(digit), 32'hF);
    chk("t6_dark_frame", 32'(frame_start), 32'd0);
    reset = 0;
    n = 0;
    do begin @(negedge clk); n++; end while (frame_start !== 1'b1 && n < 40);
    chk("t6_restart_latency", 32'(n), 32'd4);
    chk("t6_restart_digit0", 32'(digit), 32'hE);

    repeat (20) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
